// File: rtl/ras_pkg.sv
// Shared fetch-stage address type and the return-address helper used by the RAS.
package ras_pkg;

    typedef logic [31:0] addr_t;

    // Calls return past their delay slot.
    localparam addr_t RET_OFFSET = 32'd8;

    function automatic addr_t ret_addr(input addr_t pc);
        return pc + RET_OFFSET;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// One circular return-address stack with push, pop, replace-top and a full-state
// load port; the next-state bus is exported so a peer stack can be reloaded from it.
module ras_stack
    import ras_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  addr_t                   push_data,
    input  logic                    load,
    input  logic [PTR_W-1:0]        load_top,
    input  logic [CNT_W-1:0]        load_count,
    input  addr_t [DEPTH-1:0]       load_mem,
    output addr_t                   top_data,
    output logic [CNT_W-1:0]        count,
    output logic [PTR_W-1:0]        nxt_top,
    output logic [CNT_W-1:0]        nxt_count,
    output addr_t [DEPTH-1:0]       nxt_mem
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  top_q,   top_d;
    logic [CNT_W-1:0]  count_q, count_d;
    addr_t [DEPTH-1:0] mem_q,   mem_d;

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (load) begin
            top_d   = load_top;
            count_d = load_count;
            mem_d   = load_mem;
        end else if (push && (!pop || count_q == '0)) begin
            // Pointer wraps naturally; a push when full overwrites the oldest slot.
            top_d        = top_q + PTR_W'(1);
            mem_d[top_d] = push_data;
            if (count_q != FULL) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (push) begin
            mem_d[top_q] = push_data;
        end else if (pop && count_q != '0) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entries are left unreset; a zero count masks whatever they hold.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top_data  = mem_q[top_q];
    assign count     = count_q;
    assign nxt_top   = top_d;
    assign nxt_count = count_d;
    assign nxt_mem   = mem_d;

endmodule

// File: rtl/ras.sv
// Return address stack: a speculative stack driven from F1 and a committed stack
// driven from EXE; a flush reloads the speculative copy from the committed one.
module ras
    import ras_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  f1_en,
    input  logic  f1_push,
    input  logic  f1_pop,
    input  addr_t f1_pc,
    output addr_t predict_pc,
    output logic  predict_valid,
    input  logic  exe_push,
    input  logic  exe_pop,
    input  addr_t exe_pc,
    input  logic  flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    addr_t             s_top_data;
    logic [CNT_W-1:0]  s_count;
    logic [PTR_W-1:0]  s_nxt_top;
    logic [CNT_W-1:0]  s_nxt_count;
    addr_t [DEPTH-1:0] s_nxt_mem;

    addr_t             c_top_data;
    logic [CNT_W-1:0]  c_count;
    logic [PTR_W-1:0]  c_nxt_top;
    logic [CNT_W-1:0]  c_nxt_count;
    addr_t [DEPTH-1:0] c_nxt_mem;

    ras_stack #(.DEPTH(DEPTH)) u_commit (
        .clk        (clk),
        .resetn     (resetn),
        .push       (exe_push),
        .pop        (exe_pop),
        .push_data  (ret_addr(exe_pc)),
        .load       (1'b0),
        .load_top   ('0),
        .load_count ('0),
        .load_mem   ('0),
        .top_data   (c_top_data),
        .count      (c_count),
        .nxt_top    (c_nxt_top),
        .nxt_count  (c_nxt_count),
        .nxt_mem    (c_nxt_mem)
    );

    // Load takes priority inside the stack, so F1 work in a flush cycle is dropped.
    ras_stack #(.DEPTH(DEPTH)) u_spec (
        .clk        (clk),
        .resetn     (resetn),
        .push       (f1_en & f1_push),
        .pop        (f1_en & f1_pop),
        .push_data  (ret_addr(f1_pc)),
        .load       (flush),
        .load_top   (c_nxt_top),
        .load_count (c_nxt_count),
        .load_mem   (c_nxt_mem),
        .top_data   (s_top_data),
        .count      (s_count),
        .nxt_top    (s_nxt_top),
        .nxt_count  (s_nxt_count),
        .nxt_mem    (s_nxt_mem)
    );

    assign predict_valid = (s_count != '0);
    assign predict_pc    = predict_valid ? s_top_data : '0;

    logic unused_ok;
    assign unused_ok = ^{c_top_data, c_count, s_nxt_top, s_nxt_count, s_nxt_mem};

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: a queue-based reference model predicts each cycle's
// output into a scoreboard that is drained as the DUT responds.
module tb_ras;
    import ras_pkg::*;

    localparam int DEPTH = 8;

    typedef addr_t addr_q_t[$];

    typedef struct {
        logic  en;
        logic  push;
        logic  pop;
        addr_t pc;
        logic  xpush;
        logic  xpop;
        addr_t xpc;
        logic  fl;
    } op_t;

    logic  clk = 1'b0;
    logic  resetn = 1'b0;
    logic  f1_en = 1'b0, f1_push = 1'b0, f1_pop = 1'b0;
    addr_t f1_pc = '0;
    addr_t predict_pc;
    logic  predict_valid;
    logic  exe_push = 1'b0, exe_pop = 1'b0;
    addr_t exe_pc = '0;
    logic  flush = 1'b0;

    addr_q_t     sq, cq;
    logic [32:0] exp_q[$];
    logic [32:0] exp;
    int          n_run = 0;
    int          n_fail = 0;

    ras #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .f1_en         (f1_en),
        .f1_push       (f1_push),
        .f1_pop        (f1_pop),
        .f1_pc         (f1_pc),
        .predict_pc    (predict_pc),
        .predict_valid (predict_valid),
        .exe_push      (exe_push),
        .exe_pop       (exe_pop),
        .exe_pc        (exe_pc),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    function automatic addr_q_t model_op(input addr_q_t q, input logic push, input logic pop,
                                         input addr_t pc);
        addr_q_t r = q;
        if (push && pop && r.size() > 0) begin
            r[r.size()-1] = pc + 32'd8;
        end else if (push) begin
            r.push_back(pc + 32'd8);
            if (r.size() > DEPTH) void'(r.pop_front());
        end else if (pop && r.size() > 0) begin
            void'(r.pop_back());
        end
        return r;
    endfunction

    function automatic logic [32:0] model_out();
        if (sq.size() == 0) return 33'h0;
        return {1'b1, sq[sq.size()-1]};
    endfunction

    function automatic op_t mk(input logic en, input logic push, input logic pop, input addr_t pc,
                               input logic xpush, input logic xpop, input addr_t xpc,
                               input logic fl);
        op_t o;
        o.en = en; o.push = push; o.pop = pop; o.pc = pc;
        o.xpush = xpush; o.xpop = xpop; o.xpc = xpc; o.fl = fl;
        return o;
    endfunction

    task automatic step(input op_t o);
        f1_en = o.en; f1_push = o.push; f1_pop = o.pop; f1_pc = o.pc;
        exe_push = o.xpush; exe_pop = o.xpop; exe_pc = o.xpc; flush = o.fl;
        cq = model_op(cq, o.xpush, o.xpop, o.xpc);
        if (o.fl) sq = cq;
        else      sq = model_op(sq, o.en & o.push, o.en & o.pop, o.pc);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f1_en = 0; f1_push = 0; f1_pop = 0; f1_pc = '0;
        exe_push = 0; exe_pop = 0; exe_pc = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        sq.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(33'h0);
        exp = exp_q.pop_front();
        n_run++;
        if ({predict_valid, predict_pc} !== exp) begin
            n_fail++;
            $display("FAIL reset got v=%0b pc=%h want v=%0b pc=%h",
                     predict_valid, predict_pc, exp[32], exp[31:0]);
        end
        // Idle cycles must keep the empty stack empty.
        for (int i = 0; i < 2; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0));
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL reset_idle got v=%0b pc=%h want v=%0b pc=%h",
                         predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_push_pop();
        op_t ops[4];
        ops[0] = mk(1, 1, 0, 32'hBFC0_0100, 0, 0, 0, 0);
        ops[1] = mk(0, 1, 1, 32'hDEAD_0000, 0, 0, 0, 0);
        ops[2] = mk(1, 0, 1, 32'h0, 0, 0, 0, 0);
        ops[3] = mk(1, 0, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL push_pop[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
        n_run++;
        if (sq.size() != 0 || predict_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL push_pop_final got pc=%h want pc=00000000", predict_pc);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(mk(1, 1, 0, 32'h1000 + 32'(i) * 32'h10, 0, 0, 0, 0));
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL overflow_push[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
        n_run++;
        if (predict_pc !== 32'h1088) begin
            n_fail++;
            $display("FAIL overflow_top got pc=%h want pc=00001088", predict_pc);
        end
        for (int i = 0; i < 10; i++) begin
            step(mk(1, 0, 1, 0, 0, 0, 0, 0));
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL overflow_pop[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_replace_top();
        op_t ops[3];
        do_reset();
        ops[0] = mk(1, 1, 0, 32'h2000, 0, 0, 0, 0);
        ops[1] = mk(1, 1, 1, 32'h3000, 0, 0, 0, 0);
        ops[2] = mk(1, 0, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL replace_top[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_flush();
        op_t ops[4];
        do_reset();
        ops[0] = mk(1, 1, 0, 32'h4000, 1, 0, 32'h4000, 0);
        ops[1] = mk(1, 1, 0, 32'h5000, 0, 0, 0, 0);
        ops[2] = mk(1, 1, 0, 32'h8000, 0, 0, 0, 1);
        ops[3] = mk(1, 0, 1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL flush[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
            if (i == 2) begin
                n_run++;
                if (predict_pc !== 32'h4008) begin
                    n_fail++;
                    $display("FAIL flush_restore got pc=%h want pc=00004008", predict_pc);
                end
            end
        end
    endtask

    task automatic test_flush_exe_pop();
        op_t ops[5];
        do_reset();
        ops[0] = mk(1, 1, 0, 32'h6000, 1, 0, 32'h6000, 0);
        ops[1] = mk(1, 1, 0, 32'h7000, 1, 0, 32'h7000, 0);
        ops[2] = mk(1, 1, 0, 32'h9000, 0, 1, 32'h0, 1);
        ops[3] = mk(1, 0, 1, 32'h0, 0, 0, 0, 0);
        ops[4] = mk(0, 0, 0, 32'h0, 1, 1, 32'hA000, 1);
        for (int i = 0; i < 5; i++) begin
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL flush_exe_pop[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        op_t ops[3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ops[i] = mk(1, 1, 0, 32'hC000 + 32'(i) * 32'h100, 1, 0, 32'hC000 + 32'(i) * 32'h100, 0);
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL async_fill[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
        idle_inputs();
        #2;
        resetn = 1'b0;
        sq.delete();
        cq.delete();
        exp_q.push_back(33'h0);
        #1;
        exp = exp_q.pop_front();
        n_run++;
        if ({predict_valid, predict_pc} !== exp) begin
            n_fail++;
            $display("FAIL async_reset got v=%0b pc=%h want v=%0b pc=%h",
                     predict_valid, predict_pc, exp[32], exp[31:0]);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        // A flush copies C into S, exposing any count left in the committed stack.
        ops[0] = mk(0, 0, 0, 0, 0, 0, 0, 1);
        ops[1] = mk(0, 0, 0, 0, 0, 1, 0, 1);
        ops[2] = mk(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(ops[i]);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL async_after[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t o;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            o.en    = ($urandom_range(0, 3) != 0);
            o.push  = $urandom_range(0, 1) == 1;
            o.pop   = $urandom_range(0, 2) == 0;
            o.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            o.xpush = $urandom_range(0, 2) == 0;
            o.xpop  = $urandom_range(0, 3) == 0;
            o.xpc   = (i % 50 == 7) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            o.fl    = $urandom_range(0, 7) == 0;
            step(o);
            exp = exp_q.pop_front();
            n_run++;
            if ({predict_valid, predict_pc} !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got v=%0b pc=%h want v=%0b pc=%h",
                         i, predict_valid, predict_pc, exp[32], exp[31:0]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_replace_top();
        test_flush();
        test_flush_exe_pop();
        test_async_reset();
        test_back_to_back();
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
